// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: issues synchronous imem reads from the fetch PC and
// buffers {pc, instr} pairs in a small FIFO with a valid/ready decode port.
module fetch_queue #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [PC_W-1:0]            pc,
    input  logic                       halted,
    input  logic                       flush,
    output logic [PC_W-1:0]            imem_addr,
    output logic                       imem_rd_en,
    input  logic [INSTR_W-1:0]         imem_data,
    output logic                       stall,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [INSTR_W-1:0]         dec_instr,
    output logic [PC_W-1:0]            dec_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               inflight_v;
    logic [PC_W-1:0]    inflight_pc;
    logic               issue;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     occupancy;

    // Counting the in-flight read reserves its slot, so a capture never finds the FIFO full.
    always_comb begin
        occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight_v};
        stall      = n_rst & (occupancy >= (CNT_W+1)'(DEPTH));
        issue      = n_rst & ~halted & ~flush & ~stall;
        imem_rd_en = issue;
        imem_addr  = pc;
        push       = inflight_v & ~flush;
        dec_valid  = n_rst & (count != '0) & ~flush;
        pop        = dec_valid & dec_ready;
        dec_instr  = mem_instr[rd_ptr];
        dec_pc     = mem_pc[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else if (flush) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            inflight_v <= 1'b0;
        end else begin
            inflight_v <= issue;
            if (issue)
                inflight_pc <= pc;
            if (push) begin
                mem_instr[wr_ptr] <= imem_data;
                mem_pc[wr_ptr]    <= inflight_pc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    push_never_full: assert property (@(posedge clk) disable iff (!n_rst)
        push |-> (count != CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus models fetch_unit and imem, a
// separate negedge monitor checks decode output against an expected queue.
module tb_fetch_queue;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic               clk;
    logic               n_rst;
    logic [PC_W-1:0]    pc;
    logic               halted;
    logic               flush;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [PC_W-1:0]    dec_pc;
    logic [CNT_W-1:0]   count;

    fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .pc(pc), .halted(halted), .flush(flush),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
        .stall(stall), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [15:0] cur_pc;
    logic        last_issue;
    logic [15:0] last_addr;

    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of fetch_unit + imem behaviour; expected entries are queued at issue.
    task automatic cycle(input logic rst_v, input logic fl, input logic hl,
                         input logic rdy, input logic [15:0] tgt);
        @(posedge clk);
        #1;
        n_rst     = rst_v;
        flush     = fl;
        halted    = hl;
        dec_ready = rdy;
        pc        = cur_pc;
        imem_data = last_issue ? instr_of(last_addr) : 16'hDEAD;
        #1;
        if (!rst_v || fl)
            exp_q.delete();
        last_issue = imem_rd_en;
        last_addr  = imem_addr;
        if (imem_rd_en === 1'b1)
            exp_q.push_back({pc, instr_of(pc)});
        if (!rst_v)
            cur_pc = 16'h0;
        else if (fl)
            cur_pc = tgt;
        else if (imem_rd_en === 1'b1)
            cur_pc = pc + 16'h1;
    endtask

    task automatic drain(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0);
    endtask

    always @(negedge clk) begin
        if (stall === 1'b1)
            check("rd_en_while_stalled", {31'b0, imem_rd_en}, 32'h0);
        if (n_rst === 1'b1 && dec_valid === 1'b1 && dec_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %0h expected none", dec_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("dec_pc", {16'h0, dec_pc}, {16'h0, e[31:16]});
                check("dec_instr", {16'h0, dec_instr}, {16'h0, e[15:0]});
            end
        end
    end

    initial begin
        n_rst = 1'b0; flush = 1'b0; halted = 1'b0; dec_ready = 1'b0;
        pc = '0; imem_data = '0; cur_pc = 16'h0; last_issue = 1'b0; last_addr = '0;

        // 1: reset then in-order stream pc 0..5
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        check("rst_count", {29'b0, count}, 32'h0);
        check("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
        check("rst_rd_en", {31'b0, imem_rd_en}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        check("t1_first_issue", {31'b0, imem_rd_en}, 32'h1);
        check("t1_lat0_valid", {31'b0, dec_valid}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        check("t1_lat1_valid", {31'b0, dec_valid}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        check("t1_lat2_valid", {31'b0, dec_valid}, 32'h1);
        check("t1_lat2_pc", {16'h0, dec_pc}, 32'h0);
        for (int unsigned i = 0; i < 10; i++)
            cycle(1'b1, 1'b0, (cur_pc >= 16'd6), 1'b1, 16'h0);
        check("t1_drained", {29'b0, count}, 32'h0);
        check("t1_next_pc", {16'h0, cur_pc}, 32'h6);

        // 2: backpressure fills to DEPTH and stalls, then resumes in order
        for (int unsigned i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("t2_count3", {29'b0, count}, 32'h3);
        check("t2_stall_inflight", {31'b0, stall}, 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("t2_count_full", {29'b0, count}, 32'h4);
        check("t2_stall_full", {31'b0, stall}, 32'h1);
        check("t2_no_rd_en", {31'b0, imem_rd_en}, 32'h0);
        check("t2_held_pc", {16'h0, cur_pc}, 32'hA);
        for (int unsigned i = 0; i < 8; i++)
            cycle(1'b1, 1'b0, (cur_pc >= 16'd14), 1'b1, 16'h0);
        drain(6);
        check("t2_drained", {29'b0, count}, 32'h0);

        // 3: flush with count=3 and a read in flight
        for (int unsigned i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100);
        check("t3_count_pre", {29'b0, count}, 32'h3);
        check("t3_flush_gate", {31'b0, dec_valid}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        check("t3_count_post", {29'b0, count}, 32'h0);
        check("t3_valid_post", {31'b0, dec_valid}, 32'h0);
        check("t3_target_issue", {31'b0, imem_rd_en}, 32'h1);
        check("t3_target_addr", {16'h0, imem_addr}, 32'h100);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        check("t3_first_valid", {31'b0, dec_valid}, 32'h1);
        check("t3_first_pc", {16'h0, dec_pc}, 32'h100);
        drain(4);
        check("t3_drained", {29'b0, count}, 32'h0);

        // 4: steady push+pop at count=2 across 3 pointer laps
        for (int unsigned i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int unsigned i = 0; i < 3 * DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
            check("t4_count_steady", {29'b0, count}, 32'h2);
        end
        drain(5);
        check("t4_drained", {29'b0, count}, 32'h0);

        // 5: halt with a read in flight; no further issue, queue drains
        for (int unsigned i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        for (int unsigned i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0);
            check("t5_halt_no_rd_en", {31'b0, imem_rd_en}, 32'h0);
        end
        check("t5_drained", {29'b0, count}, 32'h0);
        check("t5_queue_empty", exp_q.size(), 32'h0);

        // 6: reset mid-stream with count=3, then restart from pc 0
        for (int unsigned i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("t6_rst_rd_en", {31'b0, imem_rd_en}, 32'h0);
        check("t6_rst_valid", {31'b0, dec_valid}, 32'h0);
        check("t6_rst_stall", {31'b0, stall}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        check("t6_count_post", {29'b0, count}, 32'h0);
        check("t6_valid_post", {31'b0, dec_valid}, 32'h0);
        check("t6_restart_addr", {16'h0, imem_addr}, 32'h0);
        check("t6_restart_rd_en", {31'b0, imem_rd_en}, 32'h1);
        for (int unsigned i = 0; i < 6; i++)
            cycle(1'b1, 1'b0, (cur_pc >= 16'd4), 1'b1, 16'h0);
        drain(3);
        check("t6_drained", {29'b0, count}, 32'h0);
        check("final_queue_empty", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
